// File: rtl/seg7_scan_capture.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_capture
// Brief    : Watches a multiplexed 7-segment bus, turns each stable pattern
//            back into a digit code and publishes whole frames coherently.
//            Build option SEG7_HEX_EN adds the A..F glyphs to the decoder.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_capture #(
  parameter int DIGITS     = 8,
  parameter int STABLE_CYC = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic                          iClk,
  input  logic                          iRst,
  input  logic [DIGITS-1:0]             iAnode,
  input  logic [6:0]                    iSeg,
  output logic [4*DIGITS-1:0]           oDigits,
  output logic [DIGITS-1:0]             oBlank,
  output logic [DIGITS-1:0]             oErr,
  output logic                          oDigitValid,
  output logic [$clog2(DIGITS)-1:0]     oDigitIdx,
  output logic                          oFrameValid,
  output logic                          oStale
);

  localparam int IDXW = $clog2(DIGITS);
  localparam int TOW  = $clog2(TIMEOUT + 1);

  localparam logic [1:0] c_WAIT  = 2'd0;
  localparam logic [1:0] c_DWELL = 2'd1;
  localparam logic [1:0] c_HELD  = 2'd2;

  // Returns {err, blank, code}
  function automatic logic [5:0] decodeSeg(input logic [6:0] seg);
    logic [5:0] res;
    case (seg)
      7'h40:   res = {2'b00, 4'h0};
      7'h79:   res = {2'b00, 4'h1};
      7'h24:   res = {2'b00, 4'h2};
      7'h30:   res = {2'b00, 4'h3};
      7'h19:   res = {2'b00, 4'h4};
      7'h12:   res = {2'b00, 4'h5};
      7'h02:   res = {2'b00, 4'h6};
      7'h78:   res = {2'b00, 4'h7};
      7'h00:   res = {2'b00, 4'h8};
      7'h10:   res = {2'b00, 4'h9};
`ifdef SEG7_HEX_EN
      7'h08:   res = {2'b00, 4'hA};
      7'h03:   res = {2'b00, 4'hB};
      7'h46:   res = {2'b00, 4'hC};
      7'h21:   res = {2'b00, 4'hD};
      7'h06:   res = {2'b00, 4'hE};
      7'h0E:   res = {2'b00, 4'hF};
`endif
      7'h7F:   res = {2'b01, 4'h0};
      default: res = {2'b10, 4'h0};
    endcase
    return res;
  endfunction

  logic [DIGITS-1:0]   r_sAnode;
  logic [6:0]          r_sSeg;
  logic [DIGITS-1:0]   r_holdAnode;
  logic [6:0]          r_holdSeg;
  logic [1:0]          r_state;
  logic [7:0]          r_cnt;
  logic [TOW-1:0]      r_toCnt;
  logic [DIGITS-1:0]   r_seen;
  logic [4*DIGITS-1:0] r_shDigits;
  logic [DIGITS-1:0]   r_shBlank;
  logic [DIGITS-1:0]   r_shErr;

  logic [DIGITS-1:0]   w_low;
  logic                w_valid;
  logic                w_match;
  logic [IDXW-1:0]     w_idx;
  logic [5:0]          w_dec;
  logic                w_accept;
  logic [DIGITS-1:0]   w_seenSet;
  logic                w_frameDone;
  logic                w_toHit;
  logic [4*DIGITS-1:0] w_nextDigits;
  logic [DIGITS-1:0]   w_nextBlank;
  logic [DIGITS-1:0]   w_nextErr;

  // A sample is usable only when exactly one anode is pulled low
  assign w_low     = ~r_sAnode;
  assign w_valid   = (w_low != '0) && ((w_low & (w_low - DIGITS'(1))) == '0);
  assign w_match   = (r_sAnode == r_holdAnode) && (r_sSeg == r_holdSeg);
  assign w_dec     = decodeSeg(r_sSeg);
  assign w_accept  = (r_state == c_DWELL) && w_valid && w_match &&
                     (r_cnt == 8'(STABLE_CYC - 1));
  assign w_seenSet = r_seen | w_low;
  assign w_frameDone = w_accept && (w_seenSet == {DIGITS{1'b1}});
  assign w_toHit   = !w_accept && (r_toCnt == TOW'(TIMEOUT - 1));

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_low[i]) w_idx = IDXW'(i);
    end
  end

  // Next shadow contents, so a completing frame can publish the new digit too
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_slot
    assign w_nextDigits[4*gi +: 4] = (w_accept && w_low[gi]) ? w_dec[3:0]
                                                              : r_shDigits[4*gi +: 4];
    assign w_nextBlank[gi] = (w_accept && w_low[gi]) ? w_dec[4] : r_shBlank[gi];
    assign w_nextErr[gi]   = (w_accept && w_low[gi]) ? w_dec[5] : r_shErr[gi];
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_sAnode <= '1;
      r_sSeg   <= 7'h7F;
    end else begin
      r_sAnode <= iAnode;
      r_sSeg   <= iSeg;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state     <= c_WAIT;
      r_holdAnode <= '0;
      r_holdSeg   <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        c_WAIT: begin
          if (w_valid) begin
            r_holdAnode <= r_sAnode;
            r_holdSeg   <= r_sSeg;
            r_cnt       <= 8'd1;
            r_state     <= c_DWELL;
          end
        end
        c_DWELL: begin
          if (!w_valid) begin
            r_state <= c_WAIT;
          end else if (!w_match) begin
            r_holdAnode <= r_sAnode;
            r_holdSeg   <= r_sSeg;
            r_cnt       <= 8'd1;
          end else if (w_accept) begin
            r_state <= c_HELD;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        c_HELD: begin
          if (!w_valid) begin
            r_state <= c_WAIT;
          end else if (!w_match) begin
            r_holdAnode <= r_sAnode;
            r_holdSeg   <= r_sSeg;
            r_cnt       <= 8'd1;
            r_state     <= c_DWELL;
          end
        end
        default: r_state <= c_WAIT;
      endcase
    end
  end

  // Timeout only discards the partial frame; published outputs stay intact
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_toCnt <= '0;
      r_seen  <= '0;
      oStale  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_toCnt <= '0;
      end else if (r_toCnt != TOW'(TIMEOUT)) begin
        r_toCnt <= r_toCnt + TOW'(1);
      end

      if (w_frameDone) begin
        r_seen <= '0;
        oStale <= 1'b0;
      end else if (w_accept) begin
        r_seen <= w_seenSet;
      end else if (w_toHit && (r_seen != '0)) begin
        r_seen <= '0;
        oStale <= 1'b1;
      end
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_shDigits  <= '0;
      r_shBlank   <= '0;
      r_shErr     <= '0;
      oDigits     <= '0;
      oBlank      <= '0;
      oErr        <= '0;
      oDigitValid <= 1'b0;
      oDigitIdx   <= '0;
      oFrameValid <= 1'b0;
    end else begin
      r_shDigits  <= w_nextDigits;
      r_shBlank   <= w_nextBlank;
      r_shErr     <= w_nextErr;
      oDigitValid <= w_accept;
      oFrameValid <= w_frameDone;
      if (w_accept) oDigitIdx <= w_idx;
      if (w_frameDone) begin
        oDigits <= w_nextDigits;
        oBlank  <= w_nextBlank;
        oErr    <= w_nextErr;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_capture
// Brief    : Directed and random bus traffic for seg7_scan_capture, compared
//            each cycle against a run-length reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_capture;

  localparam int DIGITS     = 8;
  localparam int STABLE_CYC = 4;
  localparam int TIMEOUT    = 200;
`ifdef SEG7_HEX_EN
  localparam bit HEX_EN = 1'b1;
`else
  localparam bit HEX_EN = 1'b0;
`endif

  logic        iClk = 1'b0;
  logic        iRst;
  logic [7:0]  iAnode;
  logic [6:0]  iSeg;
  logic [31:0] oDigits;
  logic [7:0]  oBlank;
  logic [7:0]  oErr;
  logic        oDigitValid;
  logic [2:0]  oDigitIdx;
  logic        oFrameValid;
  logic        oStale;

  seg7_scan_capture #(
    .DIGITS(DIGITS), .STABLE_CYC(STABLE_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iAnode(iAnode), .iSeg(iSeg),
    .oDigits(oDigits), .oBlank(oBlank), .oErr(oErr),
    .oDigitValid(oDigitValid), .oDigitIdx(oDigitIdx),
    .oFrameValid(oFrameValid), .oStale(oStale)
  );

  always #5 iClk = ~iClk;

  logic [6:0] segTab [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int checks = 0;
  int errors = 0;
  int obsDv  = 0;
  int obsFv  = 0;
  logic [2:0] lastFvIdx;

  // Reference model state
  logic [7:0]  mAnS;
  logic [6:0]  mSegS;
  int          mRun;
  int          mTo;
  logic [3:0]  mShCode [8];
  logic [7:0]  mShBlank, mShErr, mSeen;
  logic [31:0] eDigits;
  logic [7:0]  eBlank, eErr;
  logic        eDV, eFV, eStale;
  logic [2:0]  eIdx;

  task automatic chkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic bit oneLow(input logic [7:0] a);
    return $countones(~a) == 1;
  endfunction

  function automatic void refDecode(input logic [6:0] s, output logic [3:0] c,
                                    output logic b, output logic e);
    int lim;
    bit found;
    c = 4'h0; b = 1'b0; e = 1'b0; found = 1'b0;
    lim = HEX_EN ? 16 : 10;
    for (int i = 0; i < lim; i++) begin
      if (segTab[i] == s) begin
        c = 4'(i);
        found = 1'b1;
      end
    end
    if (!found) begin
      if (s == 7'h7F) b = 1'b1;
      else e = 1'b1;
    end
  endfunction

  function automatic void modelReset();
    mAnS = 8'hFF; mSegS = 7'h7F; mRun = 0; mTo = 0;
    for (int i = 0; i < 8; i++) mShCode[i] = 4'h0;
    mShBlank = '0; mShErr = '0; mSeen = '0;
    eDigits = '0; eBlank = '0; eErr = '0;
    eDV = 1'b0; eFV = 1'b0; eStale = 1'b0; eIdx = '0;
  endfunction

  // One clock edge: act on the previously sampled pair, then take in the new one
  function automatic void modelEdge(input logic rst, input logic [7:0] a, input logic [6:0] s);
    int pos;
    logic [3:0] c;
    logic b, e;
    if (rst) begin
      modelReset();
      return;
    end
    eDV = 1'b0;
    eFV = 1'b0;
    if (oneLow(mAnS) && mRun == STABLE_CYC) begin
      pos = 0;
      for (int i = 0; i < 8; i++) if (!mAnS[i]) pos = i;
      refDecode(mSegS, c, b, e);
      mShCode[pos] = c; mShBlank[pos] = b; mShErr[pos] = e;
      mSeen[pos] = 1'b1;
      eDV = 1'b1; eIdx = 3'(pos); mTo = 0;
      if (mSeen == 8'hFF) begin
        for (int i = 0; i < 8; i++) eDigits[4*i +: 4] = mShCode[i];
        eBlank = mShBlank; eErr = mShErr;
        eFV = 1'b1; mSeen = '0; eStale = 1'b0;
      end
    end else if (mTo < TIMEOUT) begin
      mTo++;
      if (mTo == TIMEOUT && mSeen != 0) begin
        mSeen = '0;
        eStale = 1'b1;
      end
    end
    if (oneLow(a)) mRun = (oneLow(mAnS) && a == mAnS && s == mSegS) ? mRun + 1 : 1;
    else mRun = 0;
    mAnS = a;
    mSegS = s;
  endfunction

  task automatic cyc(input logic [7:0] a, input logic [6:0] s);
    iAnode = a;
    iSeg = s;
    @(posedge iClk);
    modelEdge(iRst, a, s);
    @(negedge iClk);
    if (oDigitValid) obsDv++;
    if (oFrameValid) begin
      obsFv++;
      lastFvIdx = oDigitIdx;
    end
    chkVal("digitValid", 64'(oDigitValid), 64'(eDV));
    chkVal("frameValid", 64'(oFrameValid), 64'(eFV));
    chkVal("stale", 64'(oStale), 64'(eStale));
    chkVal("digits", 64'(oDigits), 64'(eDigits));
    chkVal("blank", 64'(oBlank), 64'(eBlank));
    chkVal("err", 64'(oErr), 64'(eErr));
    if (eDV) chkVal("digitIdx", 64'(oDigitIdx), 64'(eIdx));
  endtask

  function automatic logic [7:0] an(input int d);
    logic [7:0] v;
    v = 8'hFF;
    v[d] = 1'b0;
    return v;
  endfunction

  task automatic scanFrame(input logic [6:0] p0, input logic [6:0] p1);
    for (int d = 0; d < 8; d++) begin
      repeat (6) cyc(an(d), (d == 0) ? p0 : (d == 1) ? p1 : segTab[d]);
    end
    cyc(8'hFF, 7'h7F);
  endtask

  int dv0, fv0;
  logic [7:0] ra;
  logic [6:0] rs;
  int dur, k;

  initial begin
    iRst = 1'b1;
    iAnode = 8'hFF;
    iSeg = 7'h7F;
    lastFvIdx = '0;
    modelReset();
    repeat (2) cyc(8'hFF, 7'h7F);
    chkVal("rstDigits", 64'(oDigits), 64'h0);
    chkVal("rstFlags", 64'({oBlank, oErr, oDigitValid, oDigitIdx, oFrameValid, oStale}), 64'h0);
    iRst = 1'b0;

    // Full scan of 0..7
    dv0 = obsDv; fv0 = obsFv;
    scanFrame(7'h40, 7'h79);
    chkVal("scanDvCount", 64'(obsDv - dv0), 64'd8);
    chkVal("scanFvCount", 64'(obsFv - fv0), 64'd1);
    chkVal("scanFvIdx", 64'(lastFvIdx), 64'd7);
    chkVal("scanDigits", 64'(oDigits), 64'h76543210);
    chkVal("scanBlankErr", 64'({oBlank, oErr}), 64'h0);

    // Glitch shorter than the dwell, then a long stable hold
    dv0 = obsDv;
    repeat (3) cyc(an(2), 7'h24);
    cyc(an(2), 7'h30);
    cyc(8'hFF, 7'h7F);
    chkVal("glitchNoAccept", 64'(obsDv - dv0), 64'd0);
    repeat (50) cyc(an(2), 7'h24);
    chkVal("longHoldOnce", 64'(obsDv - dv0), 64'd1);
    cyc(8'hFF, 7'h7F);

    // Blank glyph and hex glyph in a frame
    scanFrame(7'h7F, 7'h08);
    chkVal("blankFlag0", 64'(oBlank[0]), 64'd1);
    chkVal("hexErr1", 64'(oErr[1]), HEX_EN ? 64'd0 : 64'd1);
    chkVal("hexCode1", 64'(oDigits[7:4]), HEX_EN ? 64'hA : 64'h0);

    // Partial frame then idle past the timeout
    fv0 = obsFv;
    for (int d = 0; d < 5; d++) repeat (6) cyc(an(d), segTab[d]);
    repeat (TIMEOUT + 2) cyc(8'hFF, 7'h7F);
    chkVal("staleSet", 64'(oStale), 64'd1);
    chkVal("staleNoFrame", 64'(obsFv - fv0), 64'd0);
    chkVal("staleKeepsDigits", 64'(oDigits[7:4]), HEX_EN ? 64'hA : 64'h0);
    scanFrame(7'h40, 7'h79);
    chkVal("staleRecoverFv", 64'(obsFv - fv0), 64'd1);
    chkVal("staleCleared", 64'(oStale), 64'd0);

    // Two anodes low: no accept, timeout keeps running
    repeat (6) cyc(an(4), segTab[4]);
    dv0 = obsDv;
    repeat (20) cyc(8'b1111_0011, 7'h30);
    chkVal("twoLowNoAccept", 64'(obsDv - dv0), 64'd0);
    repeat (TIMEOUT) cyc(8'b1111_0011, 7'h30);
    chkVal("twoLowTimeout", 64'(oStale), 64'd1);

    // Reset while digit 3 is dwelling
    repeat (2) cyc(an(3), 7'h30);
    iRst = 1'b1;
    #1;
    chkVal("midRstOut", 64'({oDigits, oBlank, oErr, oDigitValid, oDigitIdx, oFrameValid, oStale}), 64'h0);
    modelReset();
    repeat (2) cyc(an(3), 7'h30);
    iRst = 1'b0;
    dv0 = obsDv;
    repeat (STABLE_CYC) cyc(an(3), 7'h30);
    chkVal("midRstNoEarly", 64'(obsDv - dv0), 64'd0);
    cyc(an(3), 7'h30);
    chkVal("midRstFresh", 64'(obsDv - dv0), 64'd1);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      k = $urandom_range(0, 19);
      if (k == 0) ra = 8'hFF;
      else if (k == 1) ra = 8'($urandom);
      else ra = an($urandom_range(0, 7));
      k = $urandom_range(0, 19);
      if (k < 16) rs = segTab[k];
      else if (k < 18) rs = 7'h7F;
      else rs = 7'($urandom);
      dur = ($urandom_range(0, 99) == 0) ? $urandom_range(150, 260) : $urandom_range(1, 8);
      repeat (dur) cyc(ra, rs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Receive-side counterpart of the team's hex-to-7-segment decoder.
- Observes a time-multiplexed 7-segment display bus (one-hot active-low anodes plus active-low segments g..a) and converts each stable segment pattern back to a 4-bit digit code.
- Assembles the digits into a frame-coherent register.
- Used for loopback self-check of display drivers and for reading external display modules.

Parameters:
DIGITS, 8, number of multiplexed digit positions (anode bit i = digit i)
STABLE_CYC, 4, consecutive identical samples required to accept a digit (2..255)
TIMEOUT, 4096, cycles without an accepted digit before the partial frame is discarded

Ports:
iClk  in  1  clock
iRst  in  1  reset, asynchronous, active-high
iAnode  in  DIGITS  digit enables, active-low, one-hot
iSeg  in  7  segments, active-low, bit6=g ... bit0=a
oDigits  out  4*DIGITS  last complete frame, digit i at [4i+3:4i]
oBlank  out  DIGITS  per digit: pattern was 7'h7F (all off)
oErr  out  DIGITS  per digit: pattern unrecognised
oDigitValid  out  1  one-cycle pulse per accepted digit
oDigitIdx  out  clog2(DIGITS)  index of digit accepted with oDigitValid
oFrameValid  out  1  one-cycle pulse when oDigits/oBlank/oErr update
oStale  out  1  level: partial frame discarded by timeout, no frame completed since

Behaviour:
- Reset: all outputs 0; shadow registers, seen mask, counters cleared; FSM to WAIT.
- Inputs registered once (s_anode, s_seg); all decisions use registered values.
- Decode table (code <- pattern): 0<-40, 1<-79, 2<-24, 3<-30, 4<-19, 5<-12, 6<-02, 7<-78, 8<-00, 9<-10 (hex).
- Blank (7F): code 0, blank flag set.
- Any other pattern: code 0, err flag set.
- Valid sample: s_anode has exactly one 0 bit. All-ones or multiple zeros are invalid.
- FSM WAIT: on a valid sample, load the pair into hold registers, cnt=1, go to DWELL.
- FSM DWELL:
  - Invalid sample: go to WAIT.
  - Sample differs from hold: reload hold, cnt=1, stay in DWELL.
  - Sample matches hold: cnt++.
  - cnt reaches STABLE_CYC: accept, go to HELD.
- FSM HELD: no further accepts while the sample matches hold.
  - Sample changes to another valid pair: reload hold, cnt=1, go to DWELL.
  - Sample becomes invalid: go to WAIT.
- Latency: if a pair is presented at edges k..k+STABLE_CYC-1, oDigitValid is high in the cycle after edge k+STABLE_CYC.
- Accept:
  - Write code and flags to shadow slot idx; set seen[idx].
  - Pulse oDigitValid; drive oDigitIdx=idx.
  - Re-acceptance of the same digit in one frame overwrites the shadow slot; seen is unchanged.
- Frame complete:
  - Condition: the accept sets the last missing seen bit.
  - In the same cycle as that oDigitValid: oDigits/oBlank/oErr load the shadow, including the just-accepted digit.
  - oFrameValid pulses; seen clears; oStale clears.
- Outputs otherwise hold the last frame.
- Timeout counter:
  - Resets on every accept.
  - Saturates at TIMEOUT.
  - On reaching TIMEOUT with seen != 0: clear seen, set oStale.
  - With seen == 0 at timeout: no action.
  - Frame outputs are never cleared by timeout.
- Simultaneous accept and timeout in the same cycle: the accept wins; the counter resets.

Optional Feature:
- Macro: SEG7_HEX_EN.
- Defined: additionally decode A<-08, b<-03, C<-46, d<-21, E<-06, F<-0E to codes A..F, with flags clear.
- Undefined: these patterns are treated as unrecognised (code 0, oErr set).
- Blank and error handling are identical in both builds.

Test Plan:
- Reset mid-dwell (assert iRst for 2 cycles while digit 3 is in DWELL) -> all outputs 0 immediately; no oDigitValid afterwards until a fresh STABLE_CYC dwell.
- Scan digits 0..7 with patterns 40,79,24,30,19,12,02,78, each held 6 cycles, then all-ones for 1 cycle -> 8 oDigitValid pulses with idx 0..7, one oFrameValid coincident with idx 7, oDigits=32'h76543210, oBlank=0, oErr=0.
- Glitch: digit 2 pattern held 3 cycles (STABLE_CYC=4), then changes -> no oDigitValid for idx 2; a 4-cycle hold accepts exactly once even when held 50 cycles.
- Patterns 7F on digit 0 and 08 on digit 1 in a full frame -> oBlank[0]=1; without SEG7_HEX_EN oErr[1]=1 with code 0; with it, code 4'hA and oErr[1]=0.
- Capture 5 digits, then drive all-ones for TIMEOUT cycles -> oStale=1, no oFrameValid; the next complete 8-digit scan gives oFrameValid and oStale=0.
- iAnode=8'b11110011 (two low) held 20 cycles -> no accept; timeout counter continues running.
